// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg: shared frame constants, FSM state type and header-length helper
//   START_PATTERN/START_LEN  start-of-frame marker (three consecutive 1s on control)
//   RW_WRITE/RW_READ         encoding of the RW header bit
//   state_t                  burst_slave FSM states
//   hdr_len()                header bits after the start pattern, with or without LEN
package serial_bus_pkg;
   localparam logic [2:0] START_PATTERN = 3'b111;
   localparam int         START_LEN     = 3;
   localparam logic       RW_WRITE      = 1'b1;
   localparam logic       RW_READ       = 1'b0;
   typedef enum logic [2:0] {IDLE, HDR, WDATA, WCOMMIT, RFETCH, RSHIFT} state_t;
   function automatic int hdr_len(input int id_w, input int addr_w, input int burst_w, input logic b);
      return id_w + 2 + addr_w + (b ? burst_w : 0);
   endfunction
endpackage

// File: rtl/slave_mem.sv
// slave_mem: simple dual-port synchronous RAM, 1-cycle registered read, no reset
//   we/waddr/wdata  write port
//   re/raddr/rdata  read port, rdata updates only when re is high
module slave_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_DEPTH = 2048,
   localparam int ADDR_W    = $clog2(ADDR_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/burst_slave.sv
// burst_slave: serial-bus slave decoding control frames and running burst reads/writes on local RAM
//   clk, resetn (async active-low), slave_ID (static instance ID)
//   control        serial frame: 111 | ID | RW | B | ADDR | LEN (only if B)
//   wD/valid/last  serial write data, bit qualifier, master end-of-burst
//   rD/rvalid/rlast serial read data, qualifier, final bit of transaction
//   ready          frame or write bits can be accepted; err one-cycle abort pulse
//   Optional: define BURST_SLAVE_BCAST_EN to make the all-ones ID a write-only broadcast.
module burst_slave
   import serial_bus_pkg::*;
#(
   parameter int ADDR_DEPTH = 2048,
   parameter int DATA_WIDTH = 8,
   parameter int ID_W       = 2,
   parameter int BURST_W    = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [ID_W-1:0] slave_ID,
   input  logic            control,
   input  logic            wD,
   input  logic            valid,
   input  logic            last,
   output logic            rD,
   output logic            rvalid,
   output logic            rlast,
   output logic            ready,
   output logic            err
);
   localparam int ADDR_W = $clog2(ADDR_DEPTH);
   localparam int HW     = hdr_len(ID_W, ADDR_W, BURST_W, 1'b1);
   localparam int SW     = hdr_len(ID_W, ADDR_W, BURST_W, 1'b0);
   localparam int CW     = $clog2(HW + DATA_WIDTH + 1);

   state_t                state, nxt;
   logic [CW-1:0]         cnt;
   logic [HW-1:0]         hsr, hword;
   logic                  b_flag, last_seen, err_nxt;
   logic [ADDR_W-1:0]     addr, addr_inc;
   logic [BURST_W:0]      words;
   logic [DATA_WIDTH-1:0] wsr, rdata, rsh;
   logic [ID_W-1:0]       id_f;
   logic                  rw_f, id_match, addr_bad, hdr_last, bit_last, word_last;
   logic [ADDR_W-1:0]     addr_f;

   // Header fields are right-aligned in hword, so their position depends on whether LEN is present.
   assign hword     = {hsr[HW-2:0], control};
   assign id_f      = b_flag ? hword[HW-1 -: ID_W] : hword[SW-1 -: ID_W];
   assign rw_f      = b_flag ? hword[HW-1-ID_W] : hword[SW-1-ID_W];
   assign addr_f    = b_flag ? hword[BURST_W +: ADDR_W] : hword[ADDR_W-1:0];
   assign addr_bad  = {1'b0, addr_f} >= (ADDR_W+1)'(ADDR_DEPTH);
   assign hdr_last  = state == HDR && cnt == CW'(b_flag ? HW-1 : SW-1);
   assign bit_last  = cnt == CW'(DATA_WIDTH-1);
   assign word_last = words == (BURST_W+1)'(1);
   assign addr_inc  = addr == ADDR_W'(ADDR_DEPTH-1) ? '0 : addr + ADDR_W'(1);
`ifdef BURST_SLAVE_BCAST_EN
   // Broadcast frames are only honoured as writes; broadcast reads are dropped silently.
   assign id_match  = (&id_f) ? rw_f == RW_WRITE : id_f == slave_ID;
`else
   assign id_match  = id_f == slave_ID;
`endif

   assign ready  = state == IDLE || state == WDATA;
   assign rvalid = state == RSHIFT;
   assign rsh    = rdata << cnt;
   assign rD     = rvalid & rsh[DATA_WIDTH-1];
   assign rlast  = rvalid & bit_last & word_last;

   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= nxt;

   always_comb begin
      nxt     = state;
      err_nxt = 1'b0;
      case (state)
         IDLE:    nxt = (control && cnt == CW'(START_LEN-1)) ? HDR : IDLE;
         HDR:     if (hdr_last) begin
                     nxt     = (!id_match || addr_bad) ? IDLE : (rw_f == RW_WRITE ? WDATA : RFETCH);
                     err_nxt = id_match && addr_bad;
                  end
         WDATA:   if (valid) begin
                     nxt     = bit_last ? WCOMMIT : (last ? IDLE : WDATA);
                     err_nxt = !bit_last && last;
                  end
         WCOMMIT: nxt = (word_last || last_seen) ? IDLE : WDATA;
         RFETCH:  nxt = RSHIFT;
         RSHIFT:  if (bit_last) nxt = word_last ? IDLE : RFETCH;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         hsr       <= '0;
         b_flag    <= 1'b0;
         last_seen <= 1'b0;
         addr      <= '0;
         words     <= '0;
         wsr       <= '0;
         err       <= 1'b0;
      end else begin
         err <= err_nxt;
         case (state)
            IDLE: cnt <= (control && nxt != HDR) ? cnt + CW'(1) : '0;
            HDR: begin
               hsr <= hword;
               cnt <= hdr_last ? '0 : cnt + CW'(1);
               if (cnt == CW'(ID_W+1)) b_flag <= control;
               if (hdr_last) begin
                  addr  <= addr_f;
                  words <= b_flag ? {1'b0, hword[BURST_W-1:0]} + (BURST_W+1)'(1) : (BURST_W+1)'(1);
               end
            end
            WDATA: if (valid) begin
               wsr       <= {wsr[DATA_WIDTH-2:0], wD};
               cnt       <= (bit_last || last) ? '0 : cnt + CW'(1);
               last_seen <= last;
            end
            WCOMMIT: begin
               addr  <= addr_inc;
               words <= words - (BURST_W+1)'(1);
            end
            RSHIFT: begin
               cnt <= bit_last ? '0 : cnt + CW'(1);
               if (bit_last) begin
                  addr  <= addr_inc;
                  words <= words - (BURST_W+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

   slave_mem #(.DATA_WIDTH(DATA_WIDTH), .ADDR_DEPTH(ADDR_DEPTH)) u_mem (
      .clk   (clk),
      .we    (state == WCOMMIT),
      .waddr (addr),
      .wdata (wsr),
      .re    (state == RFETCH),
      .raddr (addr),
      .rdata (rdata)
   );
endmodule
